// File: rtl/ripple_count_sampler.sv
// Synchronous sampler for an asynchronous ripple counter: two-sample glitch filter,
// wrap-extension counter and a snapshot FIFO drained over valid/ready.
module ripple_count_sampler #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned EXT_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic                   snap_req,
  output logic [EXT_W+CNT_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   fifo_full,
  output logic                   dropped,
  output logic                   ext_ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = EXT_W + CNT_W;
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [EXT_W-1:0] EXT_ONE  = EXT_W'(1);

  logic [CNT_W-1:0] s1, s2, cur;
  logic [EXT_W-1:0] ext;
  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count, count_nxt;
  logic             pop, push;

  // A full FIFO still accepts a snapshot when the head leaves on the same edge.
  always_comb begin
    pop       = out_valid & out_ready;
    push      = snap_req & (~fifo_full | pop);
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (pop && !push)
      count_nxt = count - CNT_ONE;
  end

  assign out_data = mem[rptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      cur     <= '0;
      ext     <= '0;
      ext_ovf <= 1'b0;
    end else begin
      s1 <= cnt_in;
      s2 <= s1;
      if (s1 == s2) begin
        cur <= s2;
        if (s2 < cur) begin
          ext <= ext + EXT_ONE;
          if (ext == '1)
            ext_ovf <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      fifo_full <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + PTR_ONE;
      if (pop)
        rptr <= rptr + PTR_ONE;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      fifo_full <= (count_nxt == FULL_CNT);
      if (snap_req && !push)
        dropped <= 1'b1;
    end
  end

  // Storage needs no reset: reads are gated by out_valid.
  always_ff @(posedge clock) begin
    if (push && !reset)
      mem[wptr] <= {ext, cur};
  end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Bench for ripple_count_sampler: directed table, corner sequences and random
// stimulus compared against a lap-counting reference model.
module tb_ripple_count_sampler;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  cnt_in;
  logic        snap_req;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        fifo_full;
  logic        dropped;
  logic        ext_ovf;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model state
  logic [3:0]  samp[$];
  logic [3:0]  m_cur;
  int unsigned laps;
  logic [11:0] mq[$];
  bit          m_drop;

  ripple_count_sampler #(.CNT_W(4), .EXT_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .cnt_in   (cnt_in),
    .snap_req (snap_req),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fifo_full(fifo_full),
    .dropped  (dropped),
    .ext_ovf  (ext_ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  cnt;
    logic        snap;
    logic        rdy;
    logic        exp_valid;
    logic [11:0] exp_data;
    logic        exp_full;
    logic        exp_drop;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[14];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    samp  = '{4'd0, 4'd0};
    m_cur = '0;
    laps  = 0;
    mq.delete();
    m_drop = 1'b0;
  endtask

  // Advance model by one edge, clock the DUT, then compare all outputs.
  task automatic step();
    logic [11:0] entry;
    logic [3:0]  v;
    bit          do_pop;
    if (reset) begin
      model_reset();
    end else begin
      do_pop = (mq.size() != 0) && out_ready;
      entry  = {8'(laps), m_cur};
      if (samp[1] == samp[0]) begin
        v = samp[1];
        if (v < m_cur) laps++;
        m_cur = v;
      end
      samp.push_back(cnt_in);
      void'(samp.pop_front());
      if (do_pop) void'(mq.pop_front());
      if (snap_req) begin
        if (mq.size() < DEPTH) mq.push_back(entry);
        else m_drop = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    chk("model_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("model_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
    chk("model_dropped", 32'(dropped), 32'(m_drop));
    chk("model_ext_ovf", 32'(ext_ovf), 32'(laps >= 256));
    if (mq.size() != 0)
      chk("model_data", 32'(out_data), 32'(mq[0]));
  endtask

  task automatic drive(input logic r, input logic [3:0] c, input logic s, input logic y);
    reset = r; cnt_in = c; snap_req = s; out_ready = y;
  endtask

  task automatic hold(input logic [3:0] c, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      cnt_in = c; snap_req = 1'b0;
      step();
    end
  endtask

  initial begin
    drive(1'b1, 4'd9, 1'b0, 1'b1);
    model_reset();

    // reset, glitch filter, stable-value latency
    tbl[0]  = '{1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 12'h002, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 12'h002, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 12'h002, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 12'h002, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 12'h005, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};

    for (int unsigned i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].cnt, tbl[i].snap, tbl[i].rdy);
      step();
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
      chk("tbl_full", 32'(fifo_full), 32'(tbl[i].exp_full));
      chk("tbl_dropped", 32'(dropped), 32'(tbl[i].exp_drop));
      chk("tbl_ext_ovf", 32'(ext_ovf), 32'(tbl[i].exp_ovf));
      if (tbl[i].exp_valid)
        chk("tbl_data", 32'(out_data), 32'(tbl[i].exp_data));
    end

    // single wrap at 15->0
    hold(4'd14, 4); hold(4'd15, 4); hold(4'd0, 4); hold(4'd1, 4);
    snap_req = 1'b1; step(); snap_req = 1'b0;
    chk("wrap_once_data", 32'(out_data), 32'h011);
    step();
    // drive ext to 255, then wrap once more
    for (int unsigned i = 0; i < 254; i++) begin
      hold(4'd8, 3); hold(4'd0, 3);
    end
    snap_req = 1'b1; step(); snap_req = 1'b0;
    chk("ext_ff_data", 32'(out_data), 32'hFF0);
    chk("ext_ff_no_ovf", 32'(ext_ovf), 32'd0);
    step();
    hold(4'd8, 3); hold(4'd0, 3);
    snap_req = 1'b1; step(); snap_req = 1'b0;
    chk("ext_wrap_data", 32'(out_data), 32'h000);
    chk("ext_ovf_set", 32'(ext_ovf), 32'd1);
    step();

    // overfill with consumer stalled
    reset = 1'b1; step(); reset = 1'b0;
    hold(4'd8, 3); hold(4'd0, 3); hold(4'd8, 3); hold(4'd0, 3); hold(4'd7, 3);
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      snap_req = 1'b1; step();
    end
    snap_req = 1'b0;
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_dropped", 32'(dropped), 32'd1);
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", 32'(out_data), 32'h027);
      step();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // full FIFO with simultaneous push and pop
    reset = 1'b1; step(); reset = 1'b0;
    out_ready = 1'b0;
    hold(4'd3, 3);
    for (int unsigned i = 0; i < 4; i++) begin
      snap_req = 1'b1; step();
    end
    hold(4'd4, 3);
    snap_req = 1'b1; out_ready = 1'b1; step();
    snap_req = 1'b0; out_ready = 1'b0;
    chk("simul_full", 32'(fifo_full), 32'd1);
    chk("simul_dropped", 32'(dropped), 32'd0);
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      chk("simul_order", 32'(out_data), (i == 3) ? 32'h004 : 32'h003);
      step();
    end
    chk("simul_empty", 32'(out_valid), 32'd0);

    // reset while entries are queued
    out_ready = 1'b0;
    hold(4'd6, 3);
    snap_req = 1'b1; step(); step(); snap_req = 1'b0;
    chk("midrst_pre", 32'(out_valid), 32'd1);
    reset = 1'b1; snap_req = 1'b1; step(); reset = 1'b0; snap_req = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_full", 32'(fifo_full), 32'd0);
    snap_req = 1'b1; step(); snap_req = 1'b0;
    chk("midrst_entry", 32'(out_data), 32'h000);
    out_ready = 1'b1; step();
    chk("midrst_single", 32'(out_valid), 32'd0);

    // random traffic: runs of stable values with occasional one-cycle glitches
    for (int unsigned i = 0; i < 1500; i++) begin
      logic [3:0] v;
      int unsigned len;
      v   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 4);
      for (int unsigned j = 0; j < len; j++) begin
        reset     = ($urandom_range(0, 299) == 0);
        cnt_in    = v;
        snap_req  = ($urandom_range(0, 2) == 0);
        out_ready = ($urandom_range(0, 1) == 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
